// File: rtl/reg_parametrizado.sv
// rtl/reg_parametrizado.sv - width-parameterized load-enabled storage register
//
// Basic state element of the datapath. Each register-file entry is one
// instance of this module. The constant-zero entry R0 is also an instance,
// with load tied high and in_data tied to zero.
//
// Ports:
//   clk      - system clock; capture happens on the rising edge
//   reset    - asynchronous active-high reset; forces out_data to RESET_VALUE
//   in_data  - WIDTH-bit data to be stored
//   load     - write enable, sampled on the rising edge of clk
//   out_data - WIDTH-bit stored value, driven straight from the flops

module reg_parametrizado #(
    parameter int unsigned          WIDTH       = 64,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load,
    output logic [WIDTH-1:0] out_data
);

    // load is a flop enable (hold by feedback), never a clock gate.
    // Reset wins over any clock edge that arrives while it is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= RESET_VALUE;
        end else if (load) begin
            out_data <= in_data;
        end
    end

endmodule

// File: tb/tb_reg_parametrizado.sv
// tb/tb_reg_parametrizado.sv - directed bench for reg_parametrizado

module tb_reg_parametrizado;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] in_data;
    logic [7:0]  in8;
    logic [63:0] out64;
    logic [63:0] out_db;
    logic [7:0]  out8;
    logic [63:0] out_r0;

    int checks;
    int fails;

    reg_parametrizado #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .in_data(in_data), .load(load), .out_data(out64)
    );

    reg_parametrizado #(.WIDTH(64), .RESET_VALUE(64'hDEAD_BEEF_0000_0001)) dut_db (
        .clk(clk), .reset(reset), .in_data(in_data), .load(load), .out_data(out_db)
    );

    reg_parametrizado #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_data(in8), .load(load), .out_data(out8)
    );

    reg_parametrizado #(.WIDTH(64)) dut_r0 (
        .clk(clk), .reset(1'b0), .in_data(64'h0), .load(1'b1), .out_data(out_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] vec[3];
        checks  = 0;
        fails   = 0;
        reset   = 1'b0;
        load    = 1'b0;
        in_data = 64'h0;
        in8     = 8'h0;

        #2 reset = 1'b1;
        #1;
        checks++;
        if (out64 !== 64'h0) begin
            fails++;
            $display("FAIL async_reset_zero: got %h expected %h", out64, 64'h0);
        end
        checks++;
        if (out_db !== 64'hDEAD_BEEF_0000_0001) begin
            fails++;
            $display("FAIL async_reset_override: got %h expected %h", out_db, 64'hDEAD_BEEF_0000_0001);
        end
        checks++;
        if (out8 !== 8'h0) begin
            fails++;
            $display("FAIL async_reset_w8: got %h expected %h", out8, 8'h0);
        end

        load    = 1'b1;
        in_data = 64'hAA;
        in8     = 8'hFF;
        tick();
        checks++;
        if (out64 !== 64'h0) begin
            fails++;
            $display("FAIL reset_priority_edge: got %h expected %h", out64, 64'h0);
        end
        checks++;
        if (out_db !== 64'hDEAD_BEEF_0000_0001) begin
            fails++;
            $display("FAIL reset_priority_override: got %h expected %h", out_db, 64'hDEAD_BEEF_0000_0001);
        end
        checks++;
        if (out_r0 !== 64'h0) begin
            fails++;
            $display("FAIL r0_first_edge: got %h expected %h", out_r0, 64'h0);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out64 !== 64'h0) begin
            fails++;
            $display("FAIL reset_release_before_edge: got %h expected %h", out64, 64'h0);
        end
        tick();
        checks++;
        if (out64 !== 64'hAA) begin
            fails++;
            $display("FAIL first_capture_after_reset: got %h expected %h", out64, 64'hAA);
        end
        checks++;
        if (out_db !== 64'hAA) begin
            fails++;
            $display("FAIL first_capture_override: got %h expected %h", out_db, 64'hAA);
        end
        checks++;
        if (out8 !== 8'hFF) begin
            fails++;
            $display("FAIL w8_capture_ff: got %h expected %h", out8, 8'hFF);
        end

        in_data = 64'h0123_4567_89AB_CDEF;
        tick();
        checks++;
        if (out64 !== 64'h0123_4567_89AB_CDEF) begin
            fails++;
            $display("FAIL load_value: got %h expected %h", out64, 64'h0123_4567_89AB_CDEF);
        end
        load    = 1'b0;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out64 !== 64'h0123_4567_89AB_CDEF) begin
                fails++;
                $display("FAIL hold_edge%0d: got %h expected %h", i, out64, 64'h0123_4567_89AB_CDEF);
            end
        end

        vec[0] = 64'h1;
        vec[1] = 64'h2;
        vec[2] = 64'h3;
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vec[i];
            tick();
            checks++;
            if (out64 !== vec[i]) begin
                fails++;
                $display("FAIL b2b_%0d: got %h expected %h", i, out64, vec[i]);
            end
            checks++;
            if (out_r0 !== 64'h0) begin
                fails++;
                $display("FAIL r0_b2b_%0d: got %h expected %h", i, out_r0, 64'h0);
            end
        end

        #2 in_data = 64'h1234;
        #1;
        checks++;
        if (out64 !== 64'h3) begin
            fails++;
            $display("FAIL no_comb_path: got %h expected %h", out64, 64'h3);
        end

        in_data = 64'h5555_5555_5555_5555;
        tick();
        checks++;
        if (out64 !== 64'h5555_5555_5555_5555) begin
            fails++;
            $display("FAIL mid_preload: got %h expected %h", out64, 64'h5555_5555_5555_5555);
        end
        load = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out64 !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset_immediate: got %h expected %h", out64, 64'h0);
        end
        checks++;
        if (out_db !== 64'hDEAD_BEEF_0000_0001) begin
            fails++;
            $display("FAIL mid_reset_override: got %h expected %h", out_db, 64'hDEAD_BEEF_0000_0001);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out64 !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset_released: got %h expected %h", out64, 64'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out64 !== 64'h0) begin
                fails++;
                $display("FAIL mid_reset_hold%0d: got %h expected %h", i, out64, 64'h0);
            end
            checks++;
            if (out_db !== 64'hDEAD_BEEF_0000_0001) begin
                fails++;
                $display("FAIL mid_reset_hold_db%0d: got %h expected %h", i, out_db, 64'hDEAD_BEEF_0000_0001);
            end
        end

        load = 1'b1;
        in8  = 8'h5A;
        tick();
        checks++;
        if (out8 !== 8'h5A) begin
            fails++;
            $display("FAIL w8_capture_5a: got %h expected %h", out8, 8'h5A);
        end
        in8 = 8'hFF;
        tick();
        checks++;
        if (out8 !== 8'hFF) begin
            fails++;
            $display("FAIL w8_capture_ff_again: got %h expected %h", out8, 8'hFF);
        end
        checks++;
        if (out_r0 !== 64'h0) begin
            fails++;
            $display("FAIL r0_late_edge: got %h expected %h", out_r0, 64'h0);
        end

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
